// File: rtl/nor_1_pkg.sv
// Shared constants and helpers for the nor_1 gate primitive.
//   CovW    : number of lane-0 input combinations tracked by coverage
//   cov_idx : maps a lane-0 input pair to its coverage bit index
package nor_1_pkg;

    localparam int unsigned CovW = 4;

    function automatic logic [1:0] cov_idx(input logic a0, input logic b0);
        return {a0, b0};
    endfunction

endpackage

// File: rtl/nor_1_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports:
//   clk   : clock, rising-edge
//   rst   : synchronous active-high reset, clears count
//   inc   : increment request for this cycle
//   count : current count, holds at all ones
module nor_1_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count;
        if (inc && (count != '1)) begin
            count_d = count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/nor_1.sv
// Bitwise 2-input NOR with a registered copy and activity observability.
// Ports:
//   clk        : clock, rising-edge
//   rst        : synchronous active-high reset
//   a, b       : operands, WIDTH lanes
//   y          : combinational ~(a | b)
//   y_q        : y registered, one-cycle latency, resets to all ones
//   cov        : sticky coverage of lane-0 pairs, bit index {a[0], b[0]}
//   cov_all    : all four lane-0 pairs seen since reset
//   toggle_cnt : saturating count of y_q[0] changes
module nor_1
    import nor_1_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CovW-1:0]  cov,
    output logic             cov_all,
    output logic [CNT_W-1:0] toggle_cnt
);

    // NOR of all-zero inputs, so reset matches an idle gate.
    localparam logic [WIDTH-1:0] YqRst = '1;

    logic [CovW-1:0] cov_d;
    logic            toggle_inc;

    assign y       = ~(a | b);
    assign cov_all = &cov;

    always_comb begin
        cov_d = cov;
        cov_d[cov_idx(a[0], b[0])] = 1'b1;
    end

    // y is the value y_q takes next, so a lane-0 mismatch is a toggle.
    assign toggle_inc = (y[0] != y_q[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= YqRst;
            cov <= '0;
        end else begin
            y_q <= y;
            cov <= cov_d;
        end
    end

    nor_1_sat_counter #(
        .WIDTH (CNT_W)
    ) u_toggle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (toggle_inc),
        .count (toggle_cnt)
    );

endmodule

// File: tb/tb_nor_1.sv
module tb_nor_1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;

    logic        y1, yq1, covall1;
    logic [3:0]  cov1;
    logic [15:0] cnt1;
    logic        y2, yq2, covall2;
    logic [3:0]  cov2;
    logic [1:0]  cnt2;
    logic [3:0]  y4, yq4, cov4;
    logic        covall4;
    logic [15:0] cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit       m_yq1;
    bit [3:0] m_yq4;
    bit [3:0] m_cov;
    int       m_cnt16;
    int       m_cnt2;

    always #5 clk = ~clk;

    nor_1 #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1), .y_q(yq1),
        .cov(cov1), .cov_all(covall1), .toggle_cnt(cnt1)
    );

    nor_1 #(.WIDTH(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .y(y2), .y_q(yq2),
        .cov(cov2), .cov_all(covall2), .toggle_cnt(cnt2)
    );

    nor_1 #(.WIDTH(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .y(y4), .y_q(yq4),
        .cov(cov4), .cov_all(covall4), .toggle_cnt(cnt4)
    );

    // NOR truth table: only 00 gives 1.
    function automatic bit nor_ref(input bit x, input bit z);
        return (x == 1'b0 && z == 1'b0);
    endfunction

    function automatic bit [3:0] nor_vec(input bit [3:0] x, input bit [3:0] z);
        bit [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = nor_ref(x[i], z[i]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ia, input bit ib, input bit [3:0] ia4,
                              input bit [3:0] ib4);
        bit nyq;
        if (r) begin
            m_yq1   = 1'b1;
            m_yq4   = 4'hF;
            m_cov   = 4'h0;
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else begin
            nyq = nor_ref(ia, ib);
            if (nyq != m_yq1) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_yq1 = nyq;
            m_yq4 = nor_vec(ia4, ib4);
            m_cov[int'(ia) * 2 + int'(ib)] = 1'b1;
        end
    endtask

    // One clock cycle: drive on negedge, check y immediately, update model at posedge, check state.
    task automatic step(input bit r, input bit ia, input bit ib, input bit [3:0] ia4,
                        input bit [3:0] ib4);
        @(negedge clk);
        rst = r; a1 = ia; b1 = ib; a4 = ia4; b4 = ib4;
        #1;
        check("y1", 32'(y1), 32'(nor_ref(ia, ib)));
        check("y2", 32'(y2), 32'(nor_ref(ia, ib)));
        check("y4", 32'(y4), 32'(nor_vec(ia4, ib4)));
        @(posedge clk);
        model_edge(r, ia, ib, ia4, ib4);
        #1;
        check("y_q1", 32'(yq1), 32'(m_yq1));
        check("y_q2", 32'(yq2), 32'(m_yq1));
        check("y_q4", 32'(yq4), 32'(m_yq4));
        check("cov1", 32'(cov1), 32'(m_cov));
        check("cov2", 32'(cov2), 32'(m_cov));
        check("cov_all1", 32'(covall1), 32'(m_cov == 4'hF));
        check("cnt16", 32'(cnt1), 32'(m_cnt16));
        check("cnt2", 32'(cnt2), 32'(m_cnt2));
    endtask

    initial begin
        // Combinational truth table while reset is held.
        rst = 1'b1;
        a1 = 0; b1 = 0; #1; check("tt00", 32'(y1), 32'd1); #4;
        a1 = 0; b1 = 1; #1; check("tt01", 32'(y1), 32'd0); #4;
        a1 = 1; b1 = 0; #1; check("tt10", 32'(y1), 32'd0); #4;
        a1 = 1; b1 = 1; #1; check("tt11", 32'(y1), 32'd0); #4;

        // Reset state.
        step(1, 1, 1, 4'h0, 4'h0);
        check("rst_yq", 32'(yq1), 32'd1);
        check("rst_cov", 32'(cov1), 32'd0);
        check("rst_cnt", 32'(cnt1), 32'd0);

        // Registered path and toggle counting.
        step(0, 0, 1, 4'h0, 4'h0);
        check("reg_yq_lo", 32'(yq1), 32'd0);
        step(0, 0, 0, 4'h0, 4'h0);
        check("reg_yq_hi", 32'(yq1), 32'd1);
        check("reg_cnt2", 32'(cnt1), 32'd2);

        // Progressive coverage.
        step(1, 0, 0, 4'h0, 4'h0);
        step(0, 0, 0, 4'h0, 4'h0); check("cov_p1", 32'(cov1), 32'h1);
        step(0, 0, 1, 4'h0, 4'h0); check("cov_p2", 32'(cov1), 32'h3);
        step(0, 1, 0, 4'h0, 4'h0); check("cov_p3", 32'(cov1), 32'h7);
        check("cov_all_lo", 32'(covall1), 32'd0);
        step(0, 1, 1, 4'h0, 4'h0); check("cov_p4", 32'(cov1), 32'hF);
        check("cov_all_hi", 32'(covall1), 32'd1);

        // Bring toggle count to 5, then reset mid-operation.
        step(0, 0, 0, 4'h0, 4'h0);
        step(0, 0, 1, 4'h0, 4'h0);
        step(0, 0, 0, 4'h0, 4'h0);
        step(0, 1, 0, 4'h0, 4'h0);
        check("pre_rst_cnt", 32'(cnt1), 32'd5);
        step(1, 1, 0, 4'h0, 4'h0);
        check("mid_rst_cov", 32'(cov1), 32'd0);
        check("mid_rst_cnt", 32'(cnt1), 32'd0);
        check("mid_rst_yq", 32'(yq1), 32'd1);
        check("mid_rst_y", 32'(y1), 32'd0);

        // Saturation on the 2-bit counter.
        step(0, 1, 0, 4'h0, 4'h0); check("sat1", 32'(cnt2), 32'd1);
        step(0, 0, 0, 4'h0, 4'h0); check("sat2", 32'(cnt2), 32'd2);
        step(0, 1, 0, 4'h0, 4'h0); check("sat3", 32'(cnt2), 32'd3);
        step(0, 0, 0, 4'h0, 4'h0); check("sat4", 32'(cnt2), 32'd3);
        step(0, 1, 0, 4'h0, 4'h0); check("sat5", 32'(cnt2), 32'd3);

        // Wide lanes.
        step(0, 0, 0, 4'b0101, 4'b0011);
        check("w4_y", 32'(y4), 32'b1000);
        check("w4_yq", 32'(yq4), 32'b1000);

        // Random traffic with occasional reset.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0), 1'($urandom), 1'($urandom),
                 4'($urandom), 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nor_1.md
Name: nor_1

Overview:
- Bitwise 2-input NOR primitive for the gate-level library. Combinational output y = ~(a | b).
- Adds a registered copy of the result and small sticky observability logic: input-combination coverage and an output toggle counter, so gate activity can be checked in-system.
- Leaf block, instantiated wherever a NOR function with optional pipelining and activity visibility is needed.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q; bitwise NOR per lane.
- CNT_W, 16, width of toggle_cnt; must be >= 1.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset, sampled on the rising clk edge.
- a  input  WIDTH  Operand A.
- b  input  WIDTH  Operand B.
- y  output  WIDTH  Combinational ~(a | b); no clock or reset dependence.
- y_q  output  WIDTH  Registered y, one-cycle latency.
- cov  output  4  Sticky coverage of lane-0 input pairs; bit index = {a[0],b[0]}.
- cov_all  output  1  High when cov == 4'b1111.
- toggle_cnt  output  CNT_W  Saturating count of changes of y_q[0].

Behaviour:
- y is purely combinational and valid within the same delta as a/b changes, including while rst is high.
- Truth per lane: 00->1, 01->0, 10->0, 11->0.
- X/Z on inputs: standard Verilog NOR propagation; no masking.
- y_q: on each rising clk edge, y_q <= ~(a | b). Latency 1 cycle.
- Reset (rst=1 at a clk edge): y_q <= all ones (NOR of zero inputs), cov <= 0, toggle_cnt <= 0. cov_all is then 0. Reset wins over every other update in the same cycle.
- cov: at each non-reset edge, cov[{a[0],b[0]}] <= 1. Bits never clear except on reset. cov_all = &cov, combinational from cov.
- toggle_cnt: at each non-reset edge, if the next y_q[0] differs from the current y_q[0], increment by 1. Saturates at 2^CNT_W-1 and holds.
- The first edge after reset compares against the reset value 1. Inputs 00 therefore give no toggle; any other pair counts 1.
- Reset asserted mid-operation clears all state on that edge. The combinational y is unaffected.
- No handshake; inputs are sampled every cycle.

Decomposition:
- No shared package required.
- The reset value constant for y_q ('1) may live as a localparam.
- One natural sub-module: sat_counter (WIDTH=CNT_W, inc, rst, clk, count) for toggle_cnt.
- Keep the NOR and coverage logic in nor_1.

Test Plan:
- Combinational truth table, WIDTH=1, rst held high, no clock: apply (0,0),(0,1),(1,0),(1,1) with 5 ns spacing -> y = 1,0,0,0.
- Registered path: release rst, drive a=0,b=1 -> y_q goes 1->0 one edge later. Then a=0,b=0 -> y_q = 1 on the next edge. toggle_cnt = 2.
- Coverage: after reset, apply all four pairs one per cycle -> cov = 0001,0011,0111,1111 progressively. cov_all rises only after the fourth edge.
- Mid-operation reset: with cov=1111 and toggle_cnt=5, assert rst for one edge -> cov=0, cov_all=0, toggle_cnt=0, y_q=1. y still tracks inputs combinationally.
- Saturation: CNT_W=2, alternate a=0/1 with b=0 every cycle -> toggle_cnt goes 1,2,3,3,3.
- Width: WIDTH=4, a=4'b0101, b=4'b0011 -> y = 4'b1000 immediately, y_q = 4'b1000 one edge later.
